// File: rtl/insert_fifo.sv
// insert_fifo: serializes 128-bit cipher blocks MSB byte first
// into a byte-wide output FIFO, with a one-deep pending buffer.
module insert_fifo #(
  parameter int NBYTES = 16,
  parameter int CW     = 5
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load,
  input  logic [NBYTES*8-1:0] block_in,
  input  logic                last_in,
  input  logic [CW-1:0]       nbytes_in,
  input  logic                fifo_full,
  output logic                push,
  output logic [7:0]          data_out,
  output logic                eop,
  output logic                done,
  output logic                busy,
  output logic                overrun
);

  localparam int BW = NBYTES * 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] FULL_LIM = CW'(NBYTES);

  logic [0:0]    state;
  logic [BW-1:0] hold;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic          last;

  logic [BW-1:0] pend;
  logic [CW-1:0] pend_lim;
  logic          pend_last;
  logic          pend_valid;

  logic [CW-1:0] lim_in;
  logic          fin;

  // Byte limit for an incoming block; out-of-range counts mean a full block
  always_comb begin
    lim_in = FULL_LIM;
    if (last_in && (nbytes_in != '0) && (nbytes_in <= FULL_LIM))
      lim_in = nbytes_in;
  end

  assign push     = (state == SHIFT) && !fifo_full;
  assign fin      = push && (cnt == lim - CW'(1));
  assign data_out = hold[BW-1 -: 8];
  assign eop      = fin && last;
  assign busy     = (state == SHIFT) || pend_valid;

  // Hold register and FSM: shift on transfer, refill on the final byte
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      hold  <= '0;
      cnt   <= '0;
      lim   <= '0;
      last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            hold  <= block_in;
            cnt   <= '0;
            lim   <= lim_in;
            last  <= last_in;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (fin) begin
            cnt <= '0;
            if (pend_valid) begin
              hold <= pend;
              lim  <= pend_lim;
              last <= pend_last;
            end else if (load) begin
              hold <= block_in;
              lim  <= lim_in;
              last <= last_in;
            end else begin
              hold  <= '0;
              state <= IDLE;
            end
          end else if (push) begin
            hold <= {hold[BW-9:0], 8'h00};
            cnt  <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pending slot: catches a load while draining, drops it when occupied
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend       <= '0;
      pend_lim   <= '0;
      pend_last  <= 1'b0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (fin) begin
        if (pend_valid) begin
          pend_valid <= load;
          if (load) begin
            pend      <= block_in;
            pend_lim  <= lim_in;
            pend_last <= last_in;
          end
        end
      end else if (load && (state == SHIFT)) begin
        if (!pend_valid) begin
          pend       <= block_in;
          pend_lim   <= lim_in;
          pend_last  <= last_in;
          pend_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Completion pulse the cycle after a block's final byte
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) done <= 1'b0;
    else        done <= fin;
  end

endmodule

// File: tb/tb_insert_fifo.sv
// tb_insert_fifo: randomized and directed checks of insert_fifo
// against a byte-queue reference model.
module tb_insert_fifo;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         load;
  logic [127:0] block_in;
  logic         last_in;
  logic [4:0]   nbytes_in;
  logic         fifo_full;
  logic         push;
  logic [7:0]   data_out;
  logic         eop;
  logic         done;
  logic         busy;
  logic         overrun;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  insert_fifo #(.NBYTES(16), .CW(5)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (load),
    .block_in  (block_in),
    .last_in   (last_in),
    .nbytes_in (nbytes_in),
    .fifo_full (fifo_full),
    .push      (push),
    .data_out  (data_out),
    .eop       (eop),
    .done      (done),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Reference model: flat byte stream, each entry {final, eop, byte}
  logic [9:0]  q[$];
  int          nblk;
  logic        fin_prev;
  logic        ovr;
  logic        exp_bz;
  logic [12:0] exp_vec;

  localparam logic [127:0] BLK_A =
    128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] BLK_D =
    128'hDEAD_BEEF_0123_4567_89AB_CDEF_0123_4567;

  function automatic logic [127:0] rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {push, exp_bz ? data_out : 8'h00, eop, done, busy, overrun};
  endfunction

  task automatic model_reset();
    q.delete();
    nblk     = 0;
    fin_prev = 1'b0;
    ovr      = 1'b0;
    exp_bz   = 1'b0;
    exp_vec  = '0;
  endtask

  task automatic model_step();
    logic       p;
    logic [7:0] d;
    logic       e;
    logic       f;
    int         n;
    exp_bz  = (nblk > 0);
    p       = exp_bz && !fifo_full;
    d       = exp_bz ? q[0][7:0] : 8'h00;
    e       = p && q[0][8];
    f       = p && q[0][9];
    exp_vec = {p, d, e, fin_prev, exp_bz, ovr};
    if (p) begin
      void'(q.pop_front());
      if (f) nblk--;
    end
    fin_prev = f;
    if (load) begin
      if (nblk < 2) begin
        n = 16;
        if (last_in && nbytes_in != 0 && nbytes_in <= 16)
          n = int'(nbytes_in);
        for (int i = 0; i < n; i++)
          q.push_back({i == n - 1, last_in && (i == n - 1),
                       block_in[127 - 8*i -: 8]});
        nblk++;
      end else begin
        ovr = 1'b1;
      end
    end
  endtask

  task automatic cyc(input logic ld, input logic [127:0] b,
                     input logic lst, input logic [4:0] nb,
                     input logic full);
    @(posedge clk);
    #1;
    load      = ld;
    block_in  = b;
    last_in   = lst;
    nbytes_in = nb;
    fifo_full = full;
    @(negedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    load      = 1'b0;
    block_in  = '0;
    last_in   = 1'b0;
    nbytes_in = '0;
    fifo_full = 1'b0;
    n_rst     = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    n_rst     = 1'b0;
    load      = 1'b0;
    block_in  = '0;
    last_in   = 1'b0;
    nbytes_in = '0;
    fifo_full = 1'b0;
    model_reset();
    #12;
    n_chk++;
    if ({push, data_out, eop, done, busy, overrun} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset got=%h exp=0",
               {push, data_out, eop, done, busy, overrun});
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
      n_chk++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_basic();
    int np = 0;
    int ne = 0;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      cyc(c == 0, BLK_A, 1'b0, 5'd0, 1'b0);
      np += int'(push);
      ne += int'(eop);
      n_chk++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL basic c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
    end
    n_chk++;
    if (np != 16 || ne != 0) begin
      n_fail++;
      $display("FAIL basic_count push=%0d eop=%0d exp 16/0", np, ne);
    end
  endtask

  task automatic test_backpressure();
    int np = 0;
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      cyc(c == 0, BLK_A, 1'b0, 5'd0, (c >= 3 && c <= 5));
      np += int'(push);
      n_chk++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL bp c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
    end
    n_chk++;
    if (np != 16) begin
      n_fail++;
      $display("FAIL bp_count push=%0d exp 16", np);
    end
  endtask

  task automatic test_overlap();
    int nd = 0;
    logic [127:0] b;
    logic [127:0] c6;
    b  = rnd_blk();
    c6 = rnd_blk();
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      if (c == 0)      cyc(1'b1, BLK_A, 1'b0, 5'd0, 1'b0);
      else if (c == 4) cyc(1'b1, b, 1'b0, 5'd0, 1'b0);
      else if (c == 6) cyc(1'b1, c6, 1'b0, 5'd0, 1'b0);
      else             cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
      nd += int'(done);
      n_chk++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL overlap c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
    end
    n_chk++;
    if (nd != 2 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_end done=%0d ovr=%b exp 2/1", nd, overrun);
    end
  endtask

  task automatic test_final_load();
    logic [127:0] b;
    b = rnd_blk();
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      if (c == 0)       cyc(1'b1, BLK_A, 1'b0, 5'd0, 1'b0);
      else if (c == 16) cyc(1'b1, b, 1'b0, 5'd0, 1'b0);
      else              cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
      n_chk++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL final_load c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec);
      end
      if (c == 17) begin
        n_chk++;
        if (push !== 1'b1 || data_out !== b[127:120] || overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL final_load_next push=%b data=%h ovr=%b exp 1/%h/0",
                   push, data_out, overrun, b[127:120]);
        end
      end
    end
  endtask

  task automatic test_last();
    int np;
    int ne;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      np = 0;
      ne = 0;
      for (int c = 0; c <= 18; c++) begin
        if (c == 0)
          cyc(1'b1, k == 0 ? BLK_D : rnd_blk(), 1'b1,
              k == 0 ? 5'd5 : (k == 1 ? 5'd0 : 5'd1), 1'b0);
        else
          cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
        np += int'(push);
        ne += int'(eop);
        n_chk++;
        if (obs_vec() !== exp_vec) begin
          n_fail++;
          $display("FAIL last k=%0d c=%0d got=%h exp=%h",
                   k, c, obs_vec(), exp_vec);
        end
      end
      n_chk++;
      if (np != (k == 0 ? 5 : (k == 1 ? 16 : 1)) || ne != 1) begin
        n_fail++;
        $display("FAIL last_count k=%0d push=%0d eop=%0d", k, np, ne);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cyc($urandom_range(0, 3) == 0, rnd_blk(), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0);
      n_chk++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c == 0)      cyc(1'b1, BLK_A, 1'b0, 5'd0, 1'b0);
      else if (c == 2) cyc(1'b1, rnd_blk(), 1'b0, 5'd0, 1'b0);
      else             cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
      n_chk++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL areset_pre c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec);
      end
    end
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    n_chk++;
    if ({push, busy, done, overrun, eop} !== 5'b0) begin
      n_fail++;
      $display("FAIL areset_drop push=%b busy=%b done=%b exp 0/0/0",
               push, busy, done);
    end
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(1'b0, '0, 1'b0, 5'd0, 1'b0);
      n_chk++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL areset_post c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overlap();
    test_final_load();
    test_last();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/insert_fifo.md
Name: insert_fifo

Overview:
- Downstream counterpart of the byte-to-block extractor. Takes 128-bit blocks from the AES datapath and serializes them MSB byte first into the byte-wide output data FIFO toward the USB transmit side.
- Provides a one-deep pending buffer so the cipher can deliver a new block while the previous one is still draining.
- Honours FIFO backpressure.
- Supports a short final block: only the first N bytes are pushed and end-of-packet is flagged.

Parameters:
NBYTES, 16, bytes per block. Block width is NBYTES*8.
CW, 5, width of the byte counter and of nbytes_in. Must hold the value NBYTES.

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
load  input  1  one-cycle pulse: block_in, last_in and nbytes_in are valid
block_in  input  128  block to serialize; [127:120] is sent first
last_in  input  1  block is the final block of the packet
nbytes_in  input  5  valid bytes in a last block; 0 or >16 means 16; ignored when last_in=0
fifo_full  input  1  output FIFO cannot accept a byte this cycle
push  output  1  write strobe to the output FIFO
data_out  output  8  byte presented with push
eop  output  1  high with push on the final byte of a last block
done  output  1  one-cycle pulse, registered, the cycle after a block's final byte is pushed
busy  output  1  a block is draining or a block is pending
overrun  output  1  sticky: a load was dropped

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE; hold, pending, counters and pending-valid cleared.
  - push=0, data_out=0, eop=0, done=0, busy=0, overrun=0.
  - Takes effect immediately, including mid-block. The partial block and any pending block are discarded.
- States:
  - IDLE: no block held.
  - SHIFT: hold register draining.
- Per-block context is latched with the block:
  - hold[127:0], cnt (bytes sent, 0..16), lim (bytes to send), last flag.
  - lim = nbytes_in (sanitized per the rule above) if last_in=1, else 16.
- Output logic (combinational from registered state):
  - push = (state==SHIFT) && !fifo_full.
  - data_out = hold[127:120].
  - eop = push && last && (cnt==lim-1).
- Transfer: a byte transfers on every cycle with push=1. Then hold shifts left 8 (zero fill) and cnt increments. With fifo_full=1 everything holds.
- Final byte: a transfer with cnt==lim-1. Next cycle done=1.
- Next block on the final-byte cycle, in priority order:
  - If pending is valid: pending moves to hold and the FSM stays in SHIFT.
  - Else if load=1: the load goes directly to hold and the FSM stays in SHIFT.
  - Else: IDLE.
- Load handling:
  - IDLE + load: capture to hold, go to SHIFT. First push is possible the next cycle, so latency is 1.
  - SHIFT, not final-byte cycle, pending empty: capture to pending.
  - SHIFT, not final-byte cycle, pending full: drop the load and set overrun=1 until reset.
  - Final-byte cycle with pending full: pending moves to hold and load goes to pending. No overrun.
- busy = (state==SHIFT) || pending_valid.
- Throughput: with no backpressure a 16-byte block pushes on 16 consecutive cycles. Back-to-back blocks have zero bubble cycles.
- fifo_full toggling mid-block only stalls the block. Byte order and count are unchanged.
- A last block with lim=1 pushes a single byte with eop=1.

Test Plan:
- Reset, then load with block_in=0x00112233445566778899AABBCCDDEEFF, last_in=0, fifo_full=0 -> push high for cycles 1..16 with data_out 00,11,…,FF; eop never high; done pulses on cycle 17; busy low on cycle 17.
- Same block with fifo_full=1 on cycles 3-5 -> bytes 00,11 pushed; push=0 for 3 cycles; bytes 22..FF then follow in order; 16 pushes total; done after the 16th.
- Load A, then load B on cycle 4, then load C on cycle 6 -> all 16 bytes of A then all 16 bytes of B with no gap; C dropped; overrun=1 and stays 1; done pulses twice.
- Load A, then load B exactly on A's final-byte cycle with pending empty -> B's first byte pushes the very next cycle; no overrun.
- Load with last_in=1, nbytes_in=5, block 0xDEADBEEF01… -> 5 pushes DE,AD,BE,EF,01; eop high only with 01; done next cycle; nbytes_in=0 -> 16 pushes with eop on the 16th.
- Assert n_rst=0 during byte 7 of a block with a pending block queued -> push, busy and done drop immediately; after release no pushes occur until the next load.
